// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage occupancy states and the fetch->decode payload layout.
package pipe_pkg;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus_four;
      logic [31:0] instr;
   } fd_payload_t;

   localparam int unsigned FD_PAYLOAD_W = $bits(fd_payload_t);

   // Empty fetch->decode slot decodes as a NOP
   localparam fd_payload_t FD_BUBBLE = '{pc: 32'd0, pc_plus_four: 32'd0, instr: NOP_INSTR};

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with flush-to-bubble; REG_READY selects a two-entry skid buffer
// (registered in_ready) or a single entry (combinational in_ready).
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 96,
   parameter logic [WIDTH-1:0] BUBBLE    = {WIDTH{1'b0}},
   parameter bit               REG_READY = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_main;
   logic             w_in_fire;
   logic             w_out_fire;

   assign out_valid  = (r_state != EMPTY);
   assign out_data   = r_main;
   assign occupancy  = r_state;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   generate
      if (REG_READY) begin : g_skid
         logic [WIDTH-1:0] r_skid;

         // Flop-only ready: the skid entry absorbs the beat caught by a late out_ready drop
         assign in_ready = !reset && (r_state != FULL);

         always_ff @(posedge clk) begin
            if (reset || flush) begin
               r_state <= EMPTY;
               r_main  <= BUBBLE;
               r_skid  <= BUBBLE;
            end else begin
               case (r_state)
                  EMPTY: begin
                     if (w_in_fire) begin
                        r_main  <= in_data;
                        r_state <= ONE;
                     end
                  end
                  ONE: begin
                     if (w_in_fire && w_out_fire) begin
                        r_main <= in_data;
                     end else if (w_in_fire) begin
                        r_skid  <= in_data;
                        r_state <= FULL;
                     end else if (w_out_fire) begin
                        r_main  <= BUBBLE;
                        r_state <= EMPTY;
                     end
                  end
                  FULL: begin
                     if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_skid  <= BUBBLE;
                        r_state <= ONE;
                     end
                  end
                  default: begin
                     r_state <= EMPTY;
                     r_main  <= BUBBLE;
                     r_skid  <= BUBBLE;
                  end
               endcase
            end
         end
      end else begin : g_single
         assign in_ready = !reset && (!out_valid || out_ready);

         always_ff @(posedge clk) begin
            if (reset || flush) begin
               r_state <= EMPTY;
               r_main  <= BUBBLE;
            end else begin
               case (r_state)
                  EMPTY: begin
                     if (w_in_fire) begin
                        r_main  <= in_data;
                        r_state <= ONE;
                     end
                  end
                  ONE: begin
                     if (w_in_fire) begin
                        r_main <= in_data;
                     end else if (w_out_fire) begin
                        r_main  <= BUBBLE;
                        r_state <= EMPTY;
                     end
                  end
                  default: begin
                     r_state <= EMPTY;
                     r_main  <= BUBBLE;
                  end
               endcase
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives a skid-mode and a single-entry stage with shared stimulus; a negedge monitor
// scoreboards each against a queue of accepted beats, plus directed hand-checked points.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   fd_payload_t in_data = '0;
   logic        out_ready = 1'b0;

   logic        rdy   [2];
   logic        vld   [2];
   fd_payload_t dat   [2];
   logic [1:0]  occ   [2];

   fd_payload_t sb_q  [2][$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .WIDTH    (FD_PAYLOAD_W),
      .BUBBLE   (FD_BUBBLE),
      .REG_READY(1'b1)
   ) u_dut_skid (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (rdy[0]),
      .in_data  (in_data),
      .out_valid(vld[0]),
      .out_ready(out_ready),
      .out_data (dat[0]),
      .occupancy(occ[0])
   );

   pipe_stage_skid #(
      .WIDTH    (FD_PAYLOAD_W),
      .BUBBLE   (FD_BUBBLE),
      .REG_READY(1'b0)
   ) u_dut_single (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (rdy[1]),
      .in_data  (in_data),
      .out_valid(vld[1]),
      .out_ready(out_ready),
      .out_data (dat[1]),
      .occupancy(occ[1])
   );

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic fd_payload_t mk(input logic [31:0] pc);
      mk = '{pc: pc, pc_plus_four: pc + 32'd4, instr: pc ^ 32'h0050_0093};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // d: 0 = skid, 1 = single
   task automatic dchk(input int d, input string tag, input logic e_rdy, input logic e_vld,
                       input logic [1:0] e_occ, input fd_payload_t e_dat);
      string m;
      m = (d == 0) ? "skid" : "single";
      chk($sformatf("%s_%s_in_ready", m, tag), rdy[d], e_rdy);
      chk($sformatf("%s_%s_out_valid", m, tag), vld[d], e_vld);
      chk($sformatf("%s_%s_occupancy", m, tag), occ[d], e_occ);
      chk($sformatf("%s_%s_out_data", m, tag), dat[d], e_dat);
   endtask

   // Scoreboard: queue holds beats accepted but not yet delivered, head is the live output
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int    sz;
         logic  e_rdy;
         string m;
         m  = (d == 0) ? "sb_skid" : "sb_single";
         sz = sb_q[d].size();
         if (d == 0) e_rdy = !reset && (sz < 2);
         else        e_rdy = !reset && ((sz == 0) || out_ready);
         chk({m, "_in_ready"}, rdy[d], e_rdy);
         chk({m, "_occupancy"}, occ[d], sz[1:0]);
         chk({m, "_out_valid"}, vld[d], sz != 0);
         if (sz != 0) chk({m, "_out_data"}, dat[d], sb_q[d][0]);
         else         chk({m, "_bubble"}, dat[d], FD_BUBBLE);
         if (reset) begin
            sb_q[d].delete();
         end else begin
            if (sz != 0 && out_ready) void'(sb_q[d].pop_front());
            if (flush)                      sb_q[d].delete();
            else if (in_valid && e_rdy)     sb_q[d].push_back(in_data);
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic saved;

      // Reset held 3 cycles with a beat offered
      in_valid  = 1'b1;
      in_data   = mk(32'h0000_0f00);
      out_ready = 1'b1;
      repeat (3) begin
         cyc();
         mid();
         for (int d = 0; d < 2; d++) dchk(d, "rst", 1'b0, 1'b0, 2'd0, FD_BUBBLE);
      end
      cyc();
      reset    = 1'b0;
      in_valid = 1'b0;
      mid();
      for (int d = 0; d < 2; d++) dchk(d, "post_rst", 1'b1, 1'b0, 2'd0, FD_BUBBLE);

      // Back-to-back stream A,B,C
      cyc(); in_valid = 1'b1; in_data = mk(32'h100); mid();
      cyc(); in_data = mk(32'h104); mid();
      for (int d = 0; d < 2; d++) dchk(d, "strA", 1'b1, 1'b1, 2'd1, mk(32'h100));
      cyc(); in_data = mk(32'h108); mid();
      for (int d = 0; d < 2; d++) dchk(d, "strB", 1'b1, 1'b1, 2'd1, mk(32'h104));
      cyc(); in_valid = 1'b0; mid();
      for (int d = 0; d < 2; d++) dchk(d, "strC", 1'b1, 1'b1, 2'd1, mk(32'h108));
      cyc(); mid();
      for (int d = 0; d < 2; d++) dchk(d, "strEnd", 1'b1, 1'b0, 2'd0, FD_BUBBLE);

      // Backpressure: D accepted, E offered while out_ready low
      cyc(); in_valid = 1'b1; in_data = mk(32'h200); out_ready = 1'b1; mid();
      cyc(); in_data = mk(32'h204); out_ready = 1'b0; mid();
      dchk(0, "bpD", 1'b1, 1'b1, 2'd1, mk(32'h200));
      dchk(1, "bpD", 1'b0, 1'b1, 2'd1, mk(32'h200));
      cyc(); mid();
      dchk(0, "bpFull", 1'b0, 1'b1, 2'd2, mk(32'h200));
      dchk(1, "bpHold", 1'b0, 1'b1, 2'd1, mk(32'h200));
      cyc(); out_ready = 1'b1; mid();
      dchk(0, "bpRise", 1'b0, 1'b1, 2'd2, mk(32'h200));
      dchk(1, "bpRise", 1'b1, 1'b1, 2'd1, mk(32'h200));
      cyc(); in_valid = 1'b0; mid();
      for (int d = 0; d < 2; d++) dchk(d, "bpE", 1'b1, 1'b1, 2'd1, mk(32'h204));
      cyc(); mid();
      for (int d = 0; d < 2; d++) dchk(d, "bpEnd", 1'b1, 1'b0, 2'd0, FD_BUBBLE);

      // Flush while skid is FULL
      cyc(); in_valid = 1'b1; in_data = mk(32'h300); out_ready = 1'b0; mid();
      cyc(); in_data = mk(32'h304); mid();
      cyc(); in_data = mk(32'h308); flush = 1'b1; mid();
      dchk(0, "flFull", 1'b0, 1'b1, 2'd2, mk(32'h300));
      cyc(); flush = 1'b0; in_valid = 1'b0; mid();
      for (int d = 0; d < 2; d++) dchk(d, "flFullAfter", 1'b1, 1'b0, 2'd0, FD_BUBBLE);
      chk("flush_bubble_instr", dat[0][31:0], 32'h0000_0013);

      // Flush with both an input and an output fire
      cyc(); in_valid = 1'b1; in_data = mk(32'h400); out_ready = 1'b1; mid();
      cyc(); in_data = mk(32'h404); flush = 1'b1; mid();
      for (int d = 0; d < 2; d++) dchk(d, "flFire", 1'b1, 1'b1, 2'd1, mk(32'h400));
      cyc(); flush = 1'b0; in_valid = 1'b0; mid();
      for (int d = 0; d < 2; d++) dchk(d, "flFireAfter", 1'b1, 1'b0, 2'd0, FD_BUBBLE);

      // Random traffic; skid in_ready must not move when out_ready toggles mid-cycle
      for (int i = 0; i < 10000; i++) begin
         cyc();
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = mk($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         if (i % 7 == 0) begin
            #2;
            saved     = rdy[0];
            out_ready = ~out_ready;
            #1;
            chk("skid_ready_comb_indep", rdy[0], saved);
            out_ready = ~out_ready;
         end
      end

      // Drain
      cyc(); in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      repeat (3) cyc();
      mid();
      for (int d = 0; d < 2; d++) begin
         dchk(d, "drain", 1'b1, 1'b0, 2'd0, FD_BUBBLE);
         chk($sformatf("drain_queue_%0d", d), 96'(sb_q[d].size()), 96'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, flush-to-bubble and an optional two-entry skid buffer. It replaces the fixed-width, enable/flush-only stage registers between pipeline stages, starting with fetch→decode. Payload is opaque: {pc, pc_plus_four, instr} for fetch→decode. The skid buffer keeps `in_ready` purely registered, so backpressure never forms a combinational path across the stage.

## Interface
- WIDTH, 96, payload width in bits
- BUBBLE, {WIDTH{1'b0}}, payload value held in the storage entries and driven on `out_data` whenever `out_valid`=0; fetch→decode sets the instr field to 32'h00000013 (NOP)
- REG_READY, 1, 1 = two-entry skid mode with registered `in_ready`; 0 = single-entry mode with combinational `in_ready`

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage accepts a beat this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  `out_data` holds a live beat
- out_ready  in  1  downstream takes the beat this cycle
- out_data  out  WIDTH  head payload
- occupancy  out  2  number of live entries, 0..2

## Operation
- An input fire is `in_valid & in_ready`. An output fire is `out_valid & out_ready`.
- Storage is a main entry (drives `out_data`) and a skid entry (REG_READY=1 only).
- State follows occupancy: EMPTY(0), ONE(1), FULL(2).
- Skid mode (REG_READY=1):
  - `in_ready` = !reset & (state != FULL).
  - EMPTY: on input fire, main←in; go to ONE.
  - ONE, input and output fire together: main←in; stay in ONE.
  - ONE, input fire only: skid←in; go to FULL.
  - ONE, output fire only: main←BUBBLE; go to EMPTY.
  - FULL: on output fire, main←skid and skid←BUBBLE; go to ONE. No input fire is possible in FULL.
- Single-entry mode (REG_READY=0):
  - `in_ready` = !reset & (!out_valid | out_ready).
  - Occupancy never exceeds 1.
  - Transitions are as in EMPTY/ONE, with no skid entry.
- `out_valid` = (state != EMPTY). `out_data` = main entry, which equals BUBBLE whenever the stage is empty.
- Flush:
  - Next state is EMPTY and both entries are set to BUBBLE.
  - An input fire in the flush cycle is accepted and discarded.
  - An output fire in the flush cycle counts as delivered.
- Reset has priority over flush and has identical effect on state and entries.
- Beats leave in order. No beat is duplicated or dropped except by flush.

## Timing
- Latency: a beat accepted at edge N is visible on `out_data` with `out_valid`=1 immediately after edge N.
- Throughput: 1 beat per cycle in both modes while `out_ready`=1.
- During reset and on the first cycle after it:
  - `out_valid`=0, `out_data`=BUBBLE, `occupancy`=0.
  - `in_ready`=0 while reset is high and 1 on the first cycle after release.
- Skid mode timing:
  - `in_ready` depends only on flops and reset.
  - With `out_ready` dropping in the same cycle as an input fire, the beat lands in skid; `in_ready` falls after that edge.
  - When `out_ready` rises in FULL, `in_ready` returns 1 one cycle later.
- Holding `out_ready`=0 leaves `out_data` stable for as long as it is held.
- Holding `in_valid`=0 with `out_ready`=1 drains the stage: FULL→ONE→EMPTY over 2 edges.

## Structure
- Shared package `pipe_pkg` holds:
  - the state localparams (EMPTY=2'd0, ONE=2'd1, FULL=2'd2)
  - `NOP_INSTR`=32'h00000013
  - a packed fetch→decode payload typedef (pc, pc_plus_four, instr) and its width constant
- The block is a single module, `pipe_stage_skid`, with REG_READY selected by a generate branch. No sub-module.
- `occupancy` is the state register itself, not a separate counter.

## Test plan
- Reset held for 3 cycles with `in_valid`=1 → `in_ready`=0 and `out_valid`=0 throughout; first cycle after release `in_ready`=1 and `occupancy`=0.
- Stream A,B,C on consecutive cycles with `out_ready`=1 → outputs A,B,C one cycle after each input, no gaps, `occupancy` stays 1.
- Skid mode: send A; send B with `out_ready`=0 → `occupancy`=2 and `in_ready`=0. Raise `out_ready` → A then B out on consecutive cycles, `occupancy` 2→1→0.
- FULL with A,B held, flush=1 with `in_valid`=1 carrying C → next cycle `out_valid`=0, `out_data`=BUBBLE (instr field 32'h00000013), `occupancy`=0, C never appears.
- REG_READY=0: hold A with `out_ready`=0 → `in_ready`=0. In the same cycle `out_ready` rises and `in_valid` carries B → `in_ready`=1 that cycle and B appears next cycle.
- Random `in_valid`/`out_ready` for 10k cycles in both modes → scoreboard confirms in-order, lossless delivery and that `in_ready` never depends combinationally on `out_ready` when REG_READY=1.
